fb_scanout: RTL and testbench

//  Frame-buffer scan-out stage; consumes the composited photo frame written to image memory.

---
 rtl/fb_scanout.sv | 192 +++++++++++++++++++
 tb/tb_fb_scanout.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: reads an H_RES x V_RES RGB frame raster-order from image memory and streams it out.
// Optional build macro FB_SCANOUT_SUM_EN adds frame_sum, a mod-2^24 sum of every transferred pixel.
module fb_scanout #(
  parameter int ADDR_W     = 20,
  parameter int H_RES      = 256,
  parameter int V_RES      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rd,
  input  logic [23:0]       mem_q,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
`ifdef FB_SCANOUT_SUM_EN
  ,
  output logic [23:0]       frame_sum
`endif
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(H_RES + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_mem_a;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [COL_W-1:0]  r_col;
  logic [IDX_W-1:0]  r_px_idx;
  logic              r_inflight;
  logic              r_inflight_sof;
  logic              r_inflight_eol;
  logic              r_done;

  logic [25:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_start_ok;
  logic [CNT_W:0]    w_occ;
  logic              w_issue;
  logic              w_last_rd;
  logic              w_push;
  logic              w_pop;
  logic              w_last_px;
  logic              w_valid;
  logic [25:0]       w_head;

  assign w_start_ok = (r_state == S_IDLE) && start;
  // A read is only issued when its data is guaranteed a FIFO slot one cycle later.
  assign w_occ      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue    = (r_state == S_FETCH) && (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_last_rd  = w_issue && (r_rd_idx == IDX_W'(TOTAL - 1));
  assign w_push     = r_inflight;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && pix_ready;
  assign w_last_px  = w_pop && (r_px_idx == IDX_W'(TOTAL - 1));
  assign w_head     = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_last_rd) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_px) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        busy         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_a        <= '0;
      r_rd_idx       <= '0;
      r_col          <= '0;
      r_px_idx       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_sof <= 1'b0;
      r_inflight_eol <= 1'b0;
      r_done         <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_done     <= w_last_px;
      r_inflight <= w_issue;
      if (w_start_ok) begin
        r_mem_a  <= fb_base;
        r_rd_idx <= '0;
        r_col    <= '0;
        r_px_idx <= '0;
      end else begin
        if (w_issue) begin
          r_mem_a  <= r_mem_a + ADDR_W'(1);
          r_rd_idx <= r_rd_idx + IDX_W'(1);
          r_col    <= (r_col == COL_W'(H_RES - 1)) ? '0 : r_col + COL_W'(1);
        end
        if (w_pop) begin
          r_px_idx <= r_px_idx + IDX_W'(1);
        end
      end
      // Frame markers travel with the read so they land in the FIFO beside their pixel.
      if (w_issue) begin
        r_inflight_sof <= (r_rd_idx == '0);
        r_inflight_eol <= (r_col == COL_W'(H_RES - 1));
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {r_inflight_sof, r_inflight_eol, mem_q};
    end
  end

  assign mem_a     = r_mem_a;
  assign mem_rd    = w_issue;
  assign done      = r_done;
  assign pix_valid = w_valid;
  assign pix_data  = w_valid ? w_head[23:0] : 24'h0;
  assign pix_eol   = w_valid & w_head[24];
  assign pix_sof   = w_valid & w_head[25];

`ifdef FB_SCANOUT_SUM_EN
  logic [23:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_sum <= 24'h0;
    end else if (w_pop) begin
      r_sum <= r_sum + pix_data;
    end
  end

  assign frame_sum = r_sum;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: random backpressure, directed start/reset events, reference model of pixel stream.
`timescale 1ns/1ps
module tb_fb_scanout;
  localparam int ADDR_W = 20;
  localparam int H_RES  = 16;
  localparam int V_RES  = 8;
  localparam int DEPTH  = 4;
  localparam int TOTAL  = H_RES * V_RES;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              reset, start, pix_ready;
  logic [ADDR_W-1:0] fb_base;
  logic              busy, done, mem_rd, pix_valid, pix_sof, pix_eol;
  logic [ADDR_W-1:0] mem_a;
  logic [23:0]       mem_q = 24'h0;
  logic [23:0]       pix_data;
`ifdef FB_SCANOUT_SUM_EN
  logic [23:0]       frame_sum;
`endif

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    mem_mode = 0;
  string cur_test = "init";

  always #5 clk = ~clk;

  fb_scanout #(.ADDR_W(ADDR_W), .H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .fb_base(fb_base),
    .busy(busy), .done(done), .mem_a(mem_a), .mem_rd(mem_rd), .mem_q(mem_q),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol)
`ifdef FB_SCANOUT_SUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  // Image memory contents as a pure function of address and pattern mode.
  function automatic logic [23:0] mem_word(input logic [ADDR_W-1:0] a, input int mode);
    logic [31:0] h;
    case (mode)
      0:       return {4'h0, a};
      1:       return 24'h000001;
      2:       return 24'hFFFFFF;
      default: begin
        h = {12'h0, a} * 32'h9E3779B1;
        return h[31:8];
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_q <= mem_word(mem_a, mem_mode);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_sof",   32'(pix_sof), 32'd0);
    check("rst_eol",   32'(pix_eol), 32'd0);
    check("rst_data",  32'(pix_data), 32'd0);
  endtask

  // One frame: start, per-cycle model comparison, optional restart pulse / hold / mid-frame reset.
  task automatic run_frame(input string name, input logic [ADDR_W-1:0] base, input int mode,
                           input int stall_pct, input int hold0, input int restart_cyc,
                           input int reset_px);
    int          issued, got, cyc;
    bit          done_seen, prev_stall, first_seen;
    logic [25:0] prev_out;
    logic [23:0] exp_d, exp_sum;
    cur_test   = name;
    mem_mode   = mode;
    issued     = 0; got = 0; cyc = 0;
    done_seen  = 0; prev_stall = 0; first_seen = 0;
    prev_out   = '0; exp_sum = 24'h0;
    fb_base    = base;
    start      = 1'b1;
    pix_ready  = 1'b0;
    @(posedge clk); #1;
    start   = 1'b0;
    fb_base = base ^ 20'h5A5A5;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done_seen && cyc < BUDGET) begin
      if (reset_px >= 0 && got == reset_px) begin
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check_reset_outputs();
        for (int k = 0; k < 20; k++) begin
          pix_ready = 1'b1;
          @(posedge clk); #1;
          check("post_reset_quiet", 32'({pix_valid, mem_rd, busy, done}), 32'd0);
        end
        return;
      end
      start     = (cyc == restart_cyc);
      pix_ready = (cyc < hold0) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
      check("busy", 32'(busy), 32'(got < TOTAL));
      check("done", 32'(done), 32'(got == TOTAL));
      if (done) done_seen = 1;
      if (hold0 > 0 && cyc == hold0 - 1) check("reads_during_hold", 32'(issued), 32'(DEPTH));
      if (mem_rd) begin
        check("issue_rule", 32'((issued - got) < DEPTH), 32'd1);
        check("mem_a", 32'(mem_a), 32'(ADDR_W'(base + ADDR_W'(issued))));
        issued++;
      end
      if (pix_valid && !first_seen) begin
        first_seen = 1;
        check("first_valid_cycle", 32'(cyc), 32'd2);
      end
      if (pix_valid && prev_stall)
        check("stall_stable", 32'({pix_sof, pix_eol, pix_data}), 32'(prev_out));
      if (pix_valid && pix_ready) begin
        exp_d = mem_word(ADDR_W'(base + ADDR_W'(got)), mode);
        check("pix_data", 32'(pix_data), 32'(exp_d));
        check("pix_sof", 32'(pix_sof), 32'(got == 0));
        check("pix_eol", 32'(pix_eol), 32'((got % H_RES) == H_RES - 1));
        exp_sum = exp_sum + exp_d;
        got++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_out   = {pix_sof, pix_eol, pix_data};
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("pixel_count", 32'(got), 32'(TOTAL));
    check("read_count", 32'(issued), 32'(TOTAL));
    check("after_done_idle", 32'({done, busy, pix_valid, mem_rd}), 32'd0);
`ifdef FB_SCANOUT_SUM_EN
    check("frame_sum", 32'(frame_sum), 32'(exp_sum));
    repeat (3) @(posedge clk);
    #1;
    check("frame_sum_hold", 32'(frame_sum), 32'(exp_sum));
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pix_ready = 1'b0; fb_base = '0;
    repeat (3) @(posedge clk);
    #1;
    cur_test = "reset";
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk); #1;

    cur_test = "reset_start_same";
    reset = 1'b1; start = 1'b1; fb_base = 20'h00100;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("quiet", 32'({busy, mem_rd, pix_valid}), 32'd0);

    run_frame("T1_linear",   20'h00100, 0,  0,  0, -1, -1);
    run_frame("T2_stall30",  20'h00100, 0, 30,  0, -1, -1);
    run_frame("T3_wrap",     20'hFFFC0, 3, 30,  0, -1, -1);
    run_frame("T6_hold50",   20'h00200, 0, 10, 50, -1, -1);
    run_frame("T4_restart",  20'h03000, 3, 20,  0, 60, -1);
    run_frame("T4_reset",    20'h04000, 3, 20,  0, -1, 70);
    run_frame("after_reset", 20'h12345, 3,  0,  0, -1, -1);
    run_frame("T5_ones",     20'h00000, 1,  0,  0, -1, -1);
    run_frame("T5_allff",    20'h00000, 2, 25,  0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
